div_nbit_restoring: RTL and testbench

DIV_NBIT_RESTORING -- requirements
Module: div_nbit_restoring

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_01bit_step.sv | 32 +++
 rtl/div_nbit_restoring.sv | 173 +++++++++++++++++
 tb/tb_div_nbit_restoring.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// sizing helper for the iteration counter.
package div_pkg;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Width of the default configuration and its iteration-counter width.
  localparam int unsigned DIV_DEFAULT_WIDTH = 8;
  localparam int unsigned DIV_CNT_W         = $clog2(DIV_DEFAULT_WIDTH + 1);

  // Counter width for an arbitrary operand width; must hold 0..width.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_01bit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, keep or restore.
module div_01bit_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_DEFAULT_WIDTH
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic         o_q
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       borrow;
  logic       unused_bits;

  // Trial subtraction; the borrow out of the (W+1)-bit difference marks a
  // negative result, in which case the shifted remainder is restored.
  always_comb begin
    shifted         = {i_rem, i_bit};
    {borrow, diff}  = {1'b0, shifted} - {2'b00, i_div};
    o_q             = ~borrow;
    o_rem           = borrow ? shifted[W-1:0] : diff[W-1:0];
  end

  // The top bits are provably zero in the selected result (remainder < divisor).
  assign unused_bits = diff[W] ^ shifted[W];

endmodule

// File: rtl/div_nbit_restoring.sv
// Multi-cycle restoring divider, signed or unsigned per request. One quotient
// bit per cycle on operand magnitudes, then a single sign-fix cycle.
module div_nbit_restoring
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sgn,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_dbz,
  output logic                  o_ovf
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = div_cnt_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
  localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W - 1){1'b0}}};

  if ((DATA_WIDTH < 4) || ((DATA_WIDTH % 2) != 0)) begin : g_bad_width
    $error("div_nbit_restoring: DATA_WIDTH must be even and >= 4");
  end

  div_state_e     state;
  logic [CNT_W-1:0] cnt;

  // Raw operands kept for the exception checks and the divide-by-zero result.
  logic [W-1:0]   x_r;
  logic [W-1:0]   y_r;
  logic           sgn_r;

  // Working registers: partial remainder, and a shared register that shifts
  // dividend magnitude bits out of the top while quotient bits enter below.
  logic [W-1:0]   rem_r;
  logic [W-1:0]   qd_r;
  logic [W-1:0]   ymag_r;
  logic           neg_q_r;
  logic           neg_r_r;

  // Acceptance-time magnitudes and sign decisions.
  logic           x_neg;
  logic           y_neg;
  logic [W-1:0]   x_mag;
  logic [W-1:0]   y_mag;

  // Exception detection on the latched operands.
  logic           is_dbz;
  logic           is_ovf;

  // Single iteration datapath.
  logic [W-1:0]   step_rem;
  logic           step_q;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // still the correct unsigned magnitude in W bits.
  always_comb begin
    x_neg = i_sgn & i_num_x[W-1];
    y_neg = i_sgn & i_num_y[W-1];
    x_mag = x_neg ? -i_num_x : i_num_x;
    y_mag = y_neg ? -i_num_y : i_num_y;
  end

  // Exceptional operand pairs; divide-by-zero wins over overflow.
  always_comb begin
    is_dbz = (y_r == '0);
    is_ovf = sgn_r & (x_r == MOST_NEG) & (y_r == '1);
  end

  div_01bit_step #(
    .W (W)
  ) u_step (
    .i_rem (rem_r),
    .i_bit (qd_r[W-1]),
    .i_div (ymag_r),
    .o_rem (step_rem),
    .o_q   (step_q)
  );

  // Status decodes straight from the state register.
  always_comb begin
    o_busy = (state != IDLE);
    o_end  = (state == DONE);
  end

  // Sequencing, operand capture, iteration and result registers.
  // The exception checks run in the first CALC cycle on latched operands, so an
  // exceptional request reaches DONE one cycle after CALC is entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= CNT_ZERO;
      x_r     <= '0;
      y_r     <= '0;
      sgn_r   <= 1'b0;
      rem_r   <= '0;
      qd_r    <= '0;
      ymag_r  <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      o_quo   <= '0;
      o_rem   <= '0;
      o_dbz   <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            x_r     <= i_num_x;
            y_r     <= i_num_y;
            sgn_r   <= i_sgn;
            rem_r   <= '0;
            qd_r    <= x_mag;
            ymag_r  <= y_mag;
            neg_q_r <= x_neg ^ y_neg;
            neg_r_r <= x_neg;
            cnt     <= CNT_ZERO;
            state   <= CALC;
          end
        end

        CALC: begin
          if ((cnt == CNT_ZERO) && is_dbz) begin
            o_quo <= '1;
            o_rem <= x_r;
            o_dbz <= 1'b1;
            o_ovf <= 1'b0;
            state <= DONE;
          end else if ((cnt == CNT_ZERO) && is_ovf) begin
            o_quo <= MOST_NEG;
            o_rem <= '0;
            o_dbz <= 1'b0;
            o_ovf <= 1'b1;
            state <= DONE;
          end else begin
            rem_r <= step_rem;
            qd_r  <= {qd_r[W-2:0], step_q};
            cnt   <= cnt + CNT_ONE;
            if (cnt == LAST_ITER) begin
              state <= FIX;
            end
          end
        end

        FIX: begin
          o_quo <= neg_q_r ? -qd_r : qd_r;
          o_rem <= neg_r_r ? -rem_r : rem_r;
          o_dbz <= 1'b0;
          o_ovf <= 1'b0;
          state <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_nbit_restoring.sv
// Scoreboard bench for div_nbit_restoring: a driver pushes reference results
// computed with plain integer division; a monitor pops them on every o_end.
module tb_div_nbit_restoring;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W - 1){1'b0}}};

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;
    int unsigned  lat;
    int unsigned  issue_cyc;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] num_x;
  logic [W-1:0] num_y;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dbz;
  logic         ovf;

  exp_t        exp_q[$];
  int unsigned cyc    = 0;
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;

  div_nbit_restoring #(
    .DATA_WIDTH (W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sgn   (sgn),
    .i_num_x (num_x),
    .i_num_y (num_y),
    .o_busy  (busy),
    .o_end   (done),
    .o_quo   (quo),
    .o_rem   (rem),
    .o_dbz   (dbz),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: truncating integer division, remainder follows the dividend.
  function automatic exp_t model(input logic s, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input string name);
    exp_t e;
    int   sx, sy, q, r;
    e.name = name;
    e.issue_cyc = 0;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 2;
    if (y == 0) begin
      e.quo = '1; e.rem = x; e.dbz = 1'b1; e.lat = 2;
    end else if (s && x == MOST_NEG && y == '1) begin
      e.quo = MOST_NEG; e.rem = '0; e.ovf = 1'b1; e.lat = 2;
    end else if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      e.quo = W'(q);
      e.rem = W'(r);
    end else begin
      e.quo = x / y;
      e.rem = x % y;
    end
    return e;
  endfunction

  // Monitor: every o_end must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_end: o_end=1 quo=%h rem=%h at cycle %0d, no request outstanding",
                 quo, rem, cyc);
      end else begin
        e = exp_q.pop_front();
        if (quo !== e.quo || rem !== e.rem || dbz !== e.dbz || ovf !== e.ovf ||
            (cyc - e.issue_cyc) != e.lat) begin
          n_err++;
          $display("FAIL %s: got quo=%h rem=%h dbz=%b ovf=%b lat=%0d, expected quo=%h rem=%h dbz=%b ovf=%b lat=%0d",
                   e.name, quo, rem, dbz, ovf, cyc - e.issue_cyc,
                   e.quo, e.rem, e.dbz, e.ovf, e.lat);
        end
      end
    end
  end

  task automatic check_cleared(input string name);
    n_vec++;
    if ({busy, done, quo, rem, dbz, ovf} !== '0) begin
      n_err++;
      $display("FAIL %s: got busy=%b end=%b quo=%h rem=%h dbz=%b ovf=%b, expected all zero",
               name, busy, done, quo, rem, dbz, ovf);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input string name);
    exp_t e;
    int unsigned guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      n_vec++; n_err++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, busy, guard);
    end
    e = model(s, x, y, name);
    e.issue_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b1; sgn = s; num_x = x; num_y = y;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy: got busy=%b after acceptance, expected 1", name, busy);
    end
  endtask

  task automatic drain(input string name);
    int unsigned guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain_timeout: %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    int unsigned  pick;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; num_x = '0; num_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_state");
    rst = 1'b0;

    // Directed vectors.
    issue(1'b0, 8'd100, 8'd7,  "unsigned_100_7");
    issue(1'b1, 8'h9C,  8'd7,  "signed_m100_7");
    issue(1'b0, 8'h55,  8'h00, "dbz_unsigned");
    issue(1'b1, 8'h80,  8'hFF, "ovf_signed");
    issue(1'b1, 8'h80,  8'h00, "dbz_over_ovf");
    issue(1'b0, 8'h80,  8'hFF, "unsigned_80_ff");
    issue(1'b1, 8'h80,  8'h01, "signed_minneg_by_1");
    issue(1'b1, 8'h7F,  8'h80, "signed_7f_by_minneg");
    issue(1'b1, 8'h64,  8'hF9, "signed_100_m7");
    issue(1'b0, 8'hFF,  8'hFF, "unsigned_ff_ff");
    drain("directed");

    // Second start while busy: must be ignored.
    issue(1'b0, 8'd200, 8'd9, "busy_first");
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; sgn = 1'b1; num_x = 8'h11; num_y = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    drain("busy_ignore");

    // Start during the DONE cycle: must be ignored too.
    issue(1'b0, 8'd50, 8'd0, "done_first");
    begin
      int unsigned guard = 0;
      while (!done && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    start = 1'b1; sgn = 1'b0; num_x = 8'h22; num_y = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    drain("done_ignore");

    // Reset mid-operation aborts with no o_end, then a new request runs.
    issue(1'b0, 8'd77, 8'd5, "aborted");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check_cleared("abort_reset");
    rst = 1'b0;
    issue(1'b1, 8'hE7, 8'h04, "after_abort");
    drain("after_abort");

    // Randomized pairs in both modes, with exceptional pairs mixed in.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2000; i++) begin
        rx = W'($urandom);
        ry = W'($urandom);
        pick = $urandom_range(0, 31);
        if (pick == 0) ry = '0;
        else if (pick == 1) begin rx = MOST_NEG; ry = '1; end
        issue(m[0], rx, ry, m == 0 ? "rand_unsigned" : "rand_signed");
      end
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
